// File: rtl/smm0_strassen_core.sv
`timescale 1ns/1ps
// smm0_strassen_core
// 2x2 signed matrix multiplier built on Strassen's seven products, with its
// own sequencing FSM. Results are wrap-around DATAWIDTH-bit values.
// Optional build macro SMM0_DONE_PULSE_EN adds a one-cycle `done` output.
//
// Handshake: `load` is a single-cycle start strobe with no ready/ack. It is
// sampled only while the controller is IDLE; A, B and sel are captured on
// that same edge. Strobes seen in any other state are dropped, not queued.
module smm0_strassen_core #(
   parameter int DATAWIDTH = 32,
   parameter int BLOCKSIZE = DATAWIDTH,
   parameter int BUSWIDTH  = BLOCKSIZE*4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BUSWIDTH-1:0] A,
   input  logic [BUSWIDTH-1:0] B,
   input  logic                load,
   input  logic                sel,
   output logic [BUSWIDTH-1:0] C_out,
`ifdef SMM0_DONE_PULSE_EN
   output logic                done,
`endif
   output logic [2:0]          fsm_state
);

   localparam int DW = DATAWIDTH;
   typedef logic [DW-1:0] elem_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_TS   = 3'd1,
      COMPUTE_M = 3'd2,
      COMPUTE_C = 3'd3,
      WRITE_OUT = 3'd4
   } state_t;

   state_t state;
   logic   sel_q;
   elem_t  a_q [4];
   elem_t  b_q [4];
   elem_t  t_q [7];
   elem_t  s_q [7];
   elem_t  m_q [7];
   elem_t  c_q [4];
   elem_t  t_d [7];
   elem_t  s_d [7];
   elem_t  m_d [7];
   elem_t  c_d [4];
   elem_t  b01_e;
   elem_t  b11_e;

   assign fsm_state = state;

   // Controller: accept a start in IDLE, capture operands, then walk the
   // four pipeline states unconditionally back to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         sel_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  state <= LOAD_TS;
                  sel_q <= sel;
                  for (int i = 0; i < 4; i++) begin
                     a_q[i] <= A[i*DW +: DW];
                     b_q[i] <= B[i*DW +: DW];
                  end
               end
            end
            LOAD_TS:   state <= COMPUTE_M;
            COMPUTE_M: state <= COMPUTE_C;
            COMPUTE_C: state <= WRITE_OUT;
            WRITE_OUT: state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   // Pre-addition operands. Element index 0..3 = 00,01,10,11. In vector
   // mode column 0 of B is mirrored into column 1 and the terms that only
   // feed C0/C3 are zeroed.
   always_comb begin
      b01_e = sel_q ? b_q[0] : b_q[1];
      b11_e = sel_q ? b_q[2] : b_q[3];
      t_d[0] = a_q[0] + a_q[3];
      t_d[1] = a_q[2] + a_q[3];
      t_d[2] = a_q[0];
      t_d[3] = a_q[3];
      t_d[4] = a_q[0] + a_q[1];
      t_d[5] = a_q[2] - a_q[0];
      t_d[6] = a_q[1] - a_q[3];
      s_d[0] = b_q[0] + b11_e;
      s_d[1] = b_q[0];
      s_d[2] = b01_e - b11_e;
      s_d[3] = b_q[2] - b_q[0];
      s_d[4] = b11_e;
      s_d[5] = b_q[0] + b01_e;
      s_d[6] = b_q[2] + b11_e;
      if (sel_q) begin
         t_d[0] = '0;
         t_d[5] = '0;
         t_d[6] = '0;
         s_d[0] = '0;
         s_d[5] = '0;
         s_d[6] = '0;
      end
   end

   // Seven products; the low DW bits of a two's complement product do not
   // depend on operand signedness, so a plain DW-wide multiply is exact.
   always_comb begin
      for (int i = 0; i < 7; i++) begin
         m_d[i] = t_q[i] * s_q[i];
      end
   end

   // Post-addition recombining the products into the four result elements.
   always_comb begin
      c_d[0] = sel_q ? '0 : (m_q[0] + m_q[3] - m_q[4] + m_q[6]);
      c_d[1] = m_q[2] + m_q[4];
      c_d[2] = m_q[1] + m_q[3];
      c_d[3] = sel_q ? '0 : (m_q[0] - m_q[1] + m_q[2] + m_q[5]);
   end

   // Pipeline registers, each stage loading only in its own FSM state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 7; i++) begin
            t_q[i] <= '0;
            s_q[i] <= '0;
            m_q[i] <= '0;
         end
         for (int i = 0; i < 4; i++) begin
            c_q[i] <= '0;
         end
      end else begin
         if (state == LOAD_TS) begin
            t_q <= t_d;
            s_q <= s_d;
         end
         if (state == COMPUTE_M) begin
            m_q <= m_d;
         end
         if (state == COMPUTE_C) begin
            c_q <= c_d;
         end
      end
   end

   // Output register. Vector mode places the A*b column result at
   // elements 00 and 10; c_q[0]/c_q[3] are already zero in that mode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         C_out <= '0;
      end else if (state == WRITE_OUT) begin
         if (sel_q) begin
            C_out <= {c_q[3], c_q[2], c_q[0], c_q[1]};
         end else begin
            C_out <= {c_q[3], c_q[2], c_q[1], c_q[0]};
         end
      end
   end

`ifdef SMM0_DONE_PULSE_EN
   // One-cycle completion strobe, valid together with the new C_out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done <= 1'b0;
      end else begin
         done <= (state == WRITE_OUT);
      end
   end
`endif

endmodule

// File: tb/tb_smm0_strassen_core.sv
`timescale 1ns/1ps
// Self-checking bench for smm0_strassen_core: a 32-bit instance for the
// main scenarios and an 8-bit instance for wrap-around checks. Expected
// results come from a direct row-by-column matrix product model.
module tb_smm0_strassen_core;

  typedef int mat_t [4];  // index 0..3 = element 00,01,10,11

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] A = '0, B = '0, C_out;
  logic         load = 1'b0, sel = 1'b0;
  logic [2:0]   fsm_state;
  logic [31:0]  A8 = '0, B8 = '0, C8;
  logic         load8 = 1'b0, sel8 = 1'b0;
  logic [2:0]   fsm_state8;
`ifdef SMM0_DONE_PULSE_EN
  logic         done, done8;
`endif

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  smm0_strassen_core #(.DATAWIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .load(load), .sel(sel), .C_out(C_out),
`ifdef SMM0_DONE_PULSE_EN
    .done(done),
`endif
    .fsm_state(fsm_state)
  );

  smm0_strassen_core #(.DATAWIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .A(A8), .B(B8), .load(load8), .sel(sel8), .C_out(C8),
`ifdef SMM0_DONE_PULSE_EN
    .done(done8),
`endif
    .fsm_state(fsm_state8)
  );

  // ---------------- reference model ----------------
  function automatic mat_t ref_mm(input mat_t a, input mat_t b, input logic s);
    mat_t c;
    c[0] = a[0] * b[0] + a[1] * b[2];
    c[2] = a[2] * b[0] + a[3] * b[2];
    if (s) begin
      c[1] = 0;
      c[3] = 0;
    end else begin
      c[1] = a[0] * b[1] + a[1] * b[3];
      c[3] = a[2] * b[1] + a[3] * b[3];
    end
    return c;
  endfunction

  function automatic mat_t unpack32(input logic [127:0] v);
    mat_t m;
    for (int i = 0; i < 4; i++) m[i] = int'(v[32*i +: 32]);
    return m;
  endfunction

  function automatic logic [127:0] pack32(input mat_t m);
    return {m[3], m[2], m[1], m[0]};
  endfunction

  function automatic mat_t unpack8(input logic [31:0] v);
    mat_t m;
    logic signed [7:0] e;
    for (int i = 0; i < 4; i++) begin
      e = v[8*i +: 8];
      m[i] = int'(e);
    end
    return m;
  endfunction

  function automatic logic [31:0] pack8(input mat_t m);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = m[i][7:0];
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  // Returns 1 ns after edge E0 (the edge that samples load).
  task automatic start_op(input logic [127:0] a, input logic [127:0] b, input logic s);
    @(negedge clk);
    A = a; B = b; sel = s; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic start_op8(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    A8 = a; B8 = b; sel8 = s; load8 = 1'b1;
    @(posedge clk);
    #1 load8 = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    step(3);
    checks++;
    if (C_out !== 128'h0) begin errors++; $display("FAIL reset_cout: got %h want 0", C_out); end
    checks++;
    if (C8 !== 32'h0) begin errors++; $display("FAIL reset_cout8: got %h want 0", C8); end
`ifdef SMM0_DONE_PULSE_EN
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
`endif
    @(negedge clk) rst = 1'b1;
    step(3);
    checks++;
    if (C_out !== 128'h0) begin errors++; $display("FAIL idle_after_reset: got %h want 0", C_out); end
  endtask

  task automatic test_basic();
    logic [127:0] exp = {32'd50, 32'd43, 32'd22, 32'd19};
    start_op(pack32('{1, 2, 3, 4}), pack32('{5, 6, 7, 8}), 1'b0);
    // operands and sel change right after capture; they must not matter
    A = rand128(); B = rand128(); sel = 1'b1;
    step(3);
    checks++;
    if (C_out !== 128'h0) begin errors++; $display("FAIL basic_before_e4: got %h want 0", C_out); end
`ifdef SMM0_DONE_PULSE_EN
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early: got %b want 0", done); end
`endif
    step(1);
    checks++;
    if (C_out !== exp) begin errors++; $display("FAIL basic_result: got %h want %h", C_out, exp); end
`ifdef SMM0_DONE_PULSE_EN
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL basic_done_pulse: got %b want 1", done); end
`endif
    step(1);
`ifdef SMM0_DONE_PULSE_EN
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done); end
`endif
    step(6);
    checks++;
    if (C_out !== exp) begin errors++; $display("FAIL basic_hold: got %h want %h", C_out, exp); end
  endtask

  task automatic test_sel1();
    logic [127:0] exp = pack32('{19, 0, 43, 0});
    start_op(pack32('{1, 2, 3, 4}), pack32('{5, 99, 7, 99}), 1'b1);
    sel = 1'b0;
    step(4);
    checks++;
    if (C_out !== exp) begin errors++; $display("FAIL sel1_result: got %h want %h", C_out, exp); end
  endtask

  task automatic test_signed();
    logic [127:0] exp = pack32('{-1, 2, 3, -4});
    start_op(pack32('{-1, 2, 3, -4}), pack32('{1, 0, 0, 1}), 1'b0);
    step(4);
    checks++;
    if (C_out !== exp) begin errors++; $display("FAIL signed_identity: got %h want %h", C_out, exp); end
  endtask

  task automatic test_wrap8();
    logic [31:0] a, b, exp;
    logic        s;
    start_op8({8'd0, 8'd0, 8'd0, 8'd16}, {8'd0, 8'd0, 8'd0, 8'd16}, 1'b0);
    step(4);
    checks++;
    if (C8 !== 32'h0) begin errors++; $display("FAIL wrap8_256: got %h want 0", C8); end
    start_op8({24'd0, 8'h80}, {24'd0, 8'hFF}, 1'b0);
    step(4);
    checks++;
    if (C8 !== 32'h0000_0080) begin errors++; $display("FAIL wrap8_neg128: got %h want 00000080", C8); end
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      exp = pack8(ref_mm(unpack8(a), unpack8(b), s));
      start_op8(a, b, s);
      step(4);
      checks++;
      if (C8 !== exp) begin errors++; $display("FAIL wrap8_rand%0d: got %h want %h", i, C8, exp); end
    end
  endtask

  task automatic test_busy();
    logic [127:0] a = rand128(), b = rand128(), exp;
    logic         s = 1'($urandom_range(0, 1));
    exp = pack32(ref_mm(unpack32(a), unpack32(b), s));
    start_op(a, b, s);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      load = 1'b1; A = rand128(); B = rand128(); sel = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    load = 1'b0;
    step(1);
    checks++;
    if (C_out !== exp) begin errors++; $display("FAIL busy_result: got %h want %h", C_out, exp); end
    step(6);
    checks++;
    if (C_out !== exp) begin errors++; $display("FAIL busy_no_second_write: got %h want %h", C_out, exp); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] a = rand128(), b = rand128(), exp;
    logic         s = 1'($urandom_range(0, 1));
    start_op(a, b, s);
    step(2);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (C_out !== 128'h0) begin errors++; $display("FAIL midreset_immediate: got %h want 0", C_out); end
`ifdef SMM0_DONE_PULSE_EN
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", done); end
`endif
    step(1);
    @(negedge clk) rst = 1'b1;
    step(6);
    checks++;
    if (C_out !== 128'h0) begin errors++; $display("FAIL midreset_no_write: got %h want 0", C_out); end
    a = rand128(); b = rand128(); s = 1'($urandom_range(0, 1));
    exp = pack32(ref_mm(unpack32(a), unpack32(b), s));
    start_op(a, b, s);
    step(4);
    checks++;
    if (C_out !== exp) begin errors++; $display("FAIL midreset_recover: got %h want %h", C_out, exp); end
  endtask

  task automatic test_random();
    logic [127:0] a, b, exp;
    logic         s;
    for (int i = 0; i < 20; i++) begin
      a = rand128(); b = rand128(); s = 1'($urandom_range(0, 1));
      exp = pack32(ref_mm(unpack32(a), unpack32(b), s));
      start_op(a, b, s);
      step(4);
      checks++;
      if (C_out !== exp) begin errors++; $display("FAIL random%0d: got %h want %h", i, C_out, exp); end
    end
  endtask

  // load held high: operands present at E0 and E5 are the two accepted ops.
  task automatic test_back_to_back();
    logic [127:0] exp, held;
    held = C_out;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      A = rand128(); B = rand128(); sel = 1'($urandom_range(0, 1));
      load = (k <= 5);
      if (k == 0 || k == 5) exp_q.push_back(pack32(ref_mm(unpack32(A), unpack32(B), sel)));
      @(posedge clk);
      #1;
      if (k == 4 || k == 9) begin
        held = exp_q.pop_front();
        checks++;
        if (C_out !== held) begin errors++; $display("FAIL b2b_op_at_e%0d: got %h want %h", k, C_out, held); end
      end else if (k == 7) begin
        checks++;
        if (C_out !== held) begin errors++; $display("FAIL b2b_hold_e7: got %h want %h", C_out, held); end
      end
    end
    load = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_queue_left: got %0d want 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_sel1();
    test_signed();
    test_wrap8();
    test_busy();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
